// File: rtl/hazard_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared pipeline definitions for the hazard/stall controller of the 5-stage
// MIPS core: register index width, zero register, nop encodings of the
// tracked shadow fields and the controller state encoding.
// ---------------------------------------------------------------------------
package hazard_stall_unit_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_e;

   // Tracking info for the instruction sitting in ID/EX.
   typedef struct packed {
      logic [REG_W-1:0] rw;
      logic             wb;
      logic             ld;
      logic             md;
   } idex_shadow_t;

   // Tracking info for EX/ME and ME/WR: only the writeback fields matter.
   typedef struct packed {
      logic [REG_W-1:0] rw;
      logic             wb;
   } wb_shadow_t;

   localparam idex_shadow_t IDEX_NOP = '0;
   localparam wb_shadow_t   WB_NOP   = '0;

   function automatic wb_shadow_t to_wb(input idex_shadow_t s);
      wb_shadow_t r;
      r.rw = s.rw;
      r.wb = s.wb;
      return r;
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_if
// Bundle between the pipeline datapath (master) and the hazard/stall
// controller (slave).
//   ID side   : id_Rs, id_Rt, id_use_rs, id_use_rt, id_Rw, id_wb,
//               id_memread, id_md, ex_br_taken          (master -> slave)
//   Controls  : pc_write, if_id_write, if_id_flush, id_ex_write,
//               id_ex_bubble, ex_me_bubble, md_busy     (slave -> master)
//   Tracking  : ex_me_Rw, ex_me_wb, me_wr_Rw, me_wr_wb  (slave -> master)
// ---------------------------------------------------------------------------
interface hazard_stall_unit_if;
   import hazard_stall_unit_pkg::*;

   logic [REG_W-1:0] id_Rs;
   logic [REG_W-1:0] id_Rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [REG_W-1:0] id_Rw;
   logic             id_wb;
   logic             id_memread;
   logic             id_md;
   logic             ex_br_taken;

   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_bubble;
   logic             ex_me_bubble;
   logic             md_busy;

   logic [REG_W-1:0] ex_me_Rw;
   logic             ex_me_wb;
   logic [REG_W-1:0] me_wr_Rw;
   logic             me_wr_wb;

   modport master (
      output id_Rs, id_Rt, id_use_rs, id_use_rt, id_Rw, id_wb, id_memread,
             id_md, ex_br_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_me_bubble, md_busy, ex_me_Rw, ex_me_wb, me_wr_Rw, me_wr_wb
   );

   modport slave (
      input  id_Rs, id_Rt, id_use_rs, id_use_rt, id_Rw, id_wb, id_memread,
             id_md, ex_br_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_me_bubble, md_busy, ex_me_Rw, ex_me_wb, me_wr_Rw, me_wr_wb
   );

endinterface

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// ---------------------------------------------------------------------------
// md_busy_counter
// Counts the remaining EX cycles of a mult/div.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : start an operation (count <= MD_LATENCY-1)
//   done       : count is 1, i.e. this is the last stall cycle
// The count decrements to 0 and then idles there until the next load.
// ---------------------------------------------------------------------------
module md_busy_counter #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(MD_LATENCY - 1);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Hazard controller for the 5-stage MIPS core. Shadows destination and
// writeback info of in-flight instructions (feeding the forwarding unit) and
// resolves load-use and mult/div hazards with stalls, bubbles and flushes.
//   clk, rst_n : clock, synchronous active-low reset
//   hz         : hazard_stall_unit_if.slave (ID inputs, controls, tracking)
//   stall_cnt, flush_cnt : statistics, only with HAZARD_STATS_EN defined
// Parameters: MD_LATENCY (EX cycles of mult/div, 2..16), CNT_W
// (2**CNT_W > MD_LATENCY).
// Optional feature macro: HAZARD_STATS_EN.
// ---------------------------------------------------------------------------
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_stall_unit_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   hz_state_e    state;
   idex_shadow_t idex;
   wb_shadow_t   exme;
   wb_shadow_t   mewr;

   logic load_use;
   logic md_start;
   logic md_done;

   logic pc_write_c;
   logic if_id_write_c;
   logic if_id_flush_c;
   logic id_ex_write_c;
   logic id_ex_bubble_c;
   logic ex_me_bubble_c;
   logic md_busy_c;

   assign load_use = idex.ld & idex.wb &
                     ((hz.id_use_rs & (hz.id_Rs == idex.rw)) |
                      (hz.id_use_rt & (hz.id_Rt == idex.rw)));

   // The mult/div is in EX while its shadow sits in idex.
   assign md_start = rst_n & (state == RUN) & idex.md;

   md_busy_counter #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_md_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (md_start),
      .done  (md_done)
   );

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would infer a latch.
   always_comb begin
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      if_id_flush_c  = 1'b0;
      id_ex_write_c  = 1'b1;
      id_ex_bubble_c = 1'b0;
      ex_me_bubble_c = 1'b0;
      md_busy_c      = 1'b0;
      if (!rst_n) begin
         pc_write_c     = 1'b0;
         if_id_write_c  = 1'b0;
         id_ex_write_c  = 1'b0;
         id_ex_bubble_c = 1'b1;
         ex_me_bubble_c = 1'b1;
      end else begin
         case (state)
            RUN: begin
               // A taken branch kills the ID instruction, so a load-use match
               // against it is irrelevant.
               if (hz.ex_br_taken) begin
                  if_id_flush_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
               end else if (load_use) begin
                  pc_write_c     = 1'b0;
                  if_id_write_c  = 1'b0;
                  id_ex_bubble_c = 1'b1;
               end
            end
            MD_BUSY: begin
               pc_write_c     = 1'b0;
               if_id_write_c  = 1'b0;
               id_ex_write_c  = 1'b0;
               ex_me_bubble_c = 1'b1;
               md_busy_c      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (idex.md) state <= MD_BUSY;
            MD_BUSY: if (md_done) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // NOTE: the shadows are plain registers, so all of them clear on reset;
   // a stale Rw/wb after reset would misdirect the forwarding unit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex <= IDEX_NOP;
         exme <= WB_NOP;
         mewr <= WB_NOP;
      end else begin
         mewr <= exme;
         exme <= ex_me_bubble_c ? WB_NOP : to_wb(idex);
         if (id_ex_write_c) begin
            if (id_ex_bubble_c) begin
               idex <= IDEX_NOP;
            end else begin
               // Writes to $0 are discarded, so never advertise them.
               idex <= '{rw: hz.id_Rw,
                         wb: hz.id_wb & (hz.id_Rw != ZERO_REG),
                         ld: hz.id_memread,
                         md: hz.id_md};
            end
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if ((state == RUN) && hz.ex_br_taken && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

   assign hz.pc_write     = pc_write_c;
   assign hz.if_id_write  = if_id_write_c;
   assign hz.if_id_flush  = if_id_flush_c;
   assign hz.id_ex_write  = id_ex_write_c;
   assign hz.id_ex_bubble = id_ex_bubble_c;
   assign hz.ex_me_bubble = ex_me_bubble_c;
   assign hz.md_busy      = md_busy_c;

   assign hz.ex_me_Rw = exme.rw;
   assign hz.ex_me_wb = exme.wb;
   assign hz.me_wr_Rw = mewr.rw;
   assign hz.me_wr_wb = mewr.wb;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit (MD_LATENCY=4). Inputs change on the
// falling edge; outputs are compared 1 ns later, away from the rising edge.
// Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_write,
// id_ex_bubble, ex_me_bubble, md_busy}.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

   localparam logic [6:0] CTL_RUN = 7'b1101000;
   localparam logic [6:0] CTL_LU  = 7'b0001100;
   localparam logic [6:0] CTL_BR  = 7'b1111100;
   localparam logic [6:0] CTL_MD  = 7'b0000011;
   localparam logic [6:0] CTL_RST = 7'b0000110;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   hazard_stall_unit_if hz ();

   hazard_stall_unit #(
      .MD_LATENCY (4),
      .CNT_W      (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [6:0] exp);
      check(tag, {25'd0, hz.pc_write, hz.if_id_write, hz.if_id_flush,
                  hz.id_ex_write, hz.id_ex_bubble, hz.ex_me_bubble,
                  hz.md_busy}, {25'd0, exp});
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [4:0] rw, input logic wb,
                         input logic ld, input logic md);
      hz.id_Rs      = rs;
      hz.id_Rt      = rt;
      hz.id_use_rs  = urs;
      hz.id_use_rt  = urt;
      hz.id_Rw      = rw;
      hz.id_wb      = wb;
      hz.id_memread = ld;
      hz.id_md      = md;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      hz.ex_br_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset: forced controls and cleared tracking.
      @(negedge clk); #1;
      chk_ctl("reset_ctl", CTL_RST);
      step(); step(); #1;
      check("reset_ex_me_Rw", 32'(hz.ex_me_Rw), 0);
      check("reset_ex_me_wb", 32'(hz.ex_me_wb), 0);
      check("reset_me_wr_wb", 32'(hz.me_wr_wb), 0);
      rst_n = 1'b1; #1;
      chk_ctl("run_idle", CTL_RUN);

      // lw $8 ; add $9,$8,$10 -> one stall cycle.
      set_id(1, 0, 1, 0, 8, 1, 1, 0); #1;
      chk_ctl("lw8_issue", CTL_RUN);
      step(); set_id(8, 10, 1, 1, 9, 1, 0, 0); #1;
      chk_ctl("lu_stall", CTL_LU);
      step(); #1;
      chk_ctl("lu_release", CTL_RUN);
      check("lu_ex_me_Rw", 32'(hz.ex_me_Rw), 8);
      check("lu_ex_me_wb", 32'(hz.ex_me_wb), 1);
      step(); #1;
      check("lu_me_wr_Rw", 32'(hz.me_wr_Rw), 8);
      check("lu_me_wr_wb", 32'(hz.me_wr_wb), 1);
      check("lu_bubble_ex_me_wb", 32'(hz.ex_me_wb), 0);

      // lw $0 ; add $9,$0,$1 -> no stall, wb suppressed.
      set_id(1, 0, 1, 0, 0, 1, 1, 0); #1;
      chk_ctl("lw0_issue", CTL_RUN);
      step(); set_id(0, 1, 1, 1, 9, 1, 0, 0); #1;
      chk_ctl("lw0_nostall", CTL_RUN);
      check("add9_ex_me_Rw", 32'(hz.ex_me_Rw), 9);
      step(); #1;
      check("lw0_ex_me_Rw", 32'(hz.ex_me_Rw), 0);
      check("lw0_ex_me_wb", 32'(hz.ex_me_wb), 0);

      // lw $8 ; add $9,$3,$4 -> independent, no stall.
      set_id(1, 0, 1, 0, 8, 1, 1, 0); #1;
      chk_ctl("lw8b_issue", CTL_RUN);
      step(); set_id(3, 4, 1, 1, 9, 1, 0, 0); #1;
      chk_ctl("indep_nostall", CTL_RUN);
      step(); #1;
      check("indep_ex_me_Rw", 32'(hz.ex_me_Rw), 8);
      check("indep_ex_me_wb", 32'(hz.ex_me_wb), 1);

      // lw $5 ; Rt-only dependency stalls.
      set_id(1, 0, 1, 0, 5, 1, 1, 0); #1;
      chk_ctl("lw5_issue", CTL_RUN);
      step(); set_id(2, 5, 1, 1, 6, 1, 0, 0); #1;
      chk_ctl("lu_rt_stall", CTL_LU);
      step(); #1;
      chk_ctl("lu_rt_release", CTL_RUN);

      // lw $5 ; matching regs but not read -> no stall.
      step(); set_id(1, 0, 1, 0, 5, 1, 1, 0); #1;
      chk_ctl("lw5b_issue", CTL_RUN);
      step(); set_id(5, 5, 0, 0, 6, 1, 0, 0); #1;
      chk_ctl("no_use_flags", CTL_RUN);

      // Taken branch in the same cycle as a load-use match.
      step(); set_id(1, 0, 1, 0, 8, 1, 1, 0); #1;
      chk_ctl("lw8c_issue", CTL_RUN);
      step(); set_id(8, 10, 1, 1, 9, 1, 0, 0); hz.ex_br_taken = 1'b1; #1;
      chk_ctl("br_over_lu", CTL_BR);
      step(); hz.ex_br_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk_ctl("br_after", CTL_RUN);
      check("br_ex_me_Rw", 32'(hz.ex_me_Rw), 8);

      // Back-to-back mult: each gets its own 3-cycle stall.
      set_id(1, 2, 1, 1, 0, 0, 0, 1); #1;
      chk_ctl("md1_issue", CTL_RUN);
      step(); #1;
      chk_ctl("md1_in_ex", CTL_RUN);
      step(); set_id(3, 4, 1, 1, 9, 1, 0, 0); #1;
      chk_ctl("md1_busy1", CTL_MD);
      step(); #1; chk_ctl("md1_busy2", CTL_MD);
      step(); #1; chk_ctl("md1_busy3", CTL_MD);
      step(); #1; chk_ctl("md2_in_ex", CTL_RUN);
      step(); #1; chk_ctl("md2_busy1", CTL_MD);
      step(); #1; chk_ctl("md2_busy2", CTL_MD);
      step(); #1; chk_ctl("md2_busy3", CTL_MD);
      step(); #1;
      chk_ctl("md2_done", CTL_RUN);
      check("md_bubble_ex_me_wb", 32'(hz.ex_me_wb), 0);
      step(); #1;
      chk_ctl("md_no_retrigger", CTL_RUN);
      check("md_next_ex_me_Rw", 32'(hz.ex_me_Rw), 9);
      check("md_next_ex_me_wb", 32'(hz.ex_me_wb), 1);

      // Reset during the second MD_BUSY cycle aborts the operation.
      set_id(1, 2, 1, 1, 0, 0, 0, 1); #1;
      chk_ctl("md3_issue", CTL_RUN);
      step(); set_id(3, 4, 1, 1, 9, 1, 0, 0); #1;
      chk_ctl("md3_in_ex", CTL_RUN);
      step(); #1; chk_ctl("md3_busy1", CTL_MD);
      step(); rst_n = 1'b0; #1;
      chk_ctl("rst_forced", CTL_RST);
      step(); rst_n = 1'b1; #1;
      chk_ctl("rst_release", CTL_RUN);
      check("rst_ex_me_Rw", 32'(hz.ex_me_Rw), 0);
      check("rst_ex_me_wb", 32'(hz.ex_me_wb), 0);
      check("rst_me_wr_wb", 32'(hz.me_wr_wb), 0);
      step(); #1;
      chk_ctl("rst_no_residual", CTL_RUN);
      check("rst_me_wr_Rw", 32'(hz.me_wr_Rw), 0);
      step(); #1;
      chk_ctl("rst_still_run", CTL_RUN);
      check("rst_add_ex_me_Rw", 32'(hz.ex_me_Rw), 9);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
